// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: FIFO of fetched {pc, instr} pairs between fetch and decode, with flush.
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            if_valid,
    input  logic [31:0]     if_pc,
    input  logic [31:0]     if_instr,
    output logic            if_ready,
    output logic            id_valid,
    output logic [31:0]     id_pc,
    output logic [31:0]     id_instr,
    input  logic            id_ready,
    output logic [CNTW-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
    logic [31:0] pc_mem [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic push, pop;
    assign if_ready = count != FULL;
    assign id_valid = count != '0;
    assign push     = if_valid & if_ready & ~flush;
    assign pop      = id_valid & id_ready & ~flush;
    // empty queue presents zeros so decode sees a NOP
    assign id_pc    = id_valid ? pc_mem[head] : 32'h0;
    assign id_instr = id_valid ? instr_mem[head] : 32'h0;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + CNTW'(push) - CNTW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[tail]    <= if_pc;
            instr_mem[tail] <= if_instr;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed and random stimulus against a queue-based reference model with a scoreboard.
module tb_inst_fetch_queue;
    localparam int DEPTH = 4;
    localparam int CNTW = 3;
    logic clk = 0;
    logic rst = 1, flush = 0, if_valid = 0, id_ready = 0;
    logic [31:0] if_pc = 0, if_instr = 0;
    logic if_ready, id_valid;
    logic [31:0] id_pc, id_instr;
    logic [CNTW-1:0] count;
    inst_fetch_queue #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc),
        .id_instr(id_instr), .id_ready(id_ready), .count(count)
    );
    always #5 clk = ~clk;
    logic [63:0] model[$];
    logic [63:0] exp_q[$];
    int exp_cnt = 0;
    logic [63:0] exp_head = 0;
    bit armed = 0;
    int passed = 0, total = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask
    // Apply one cycle of inputs and advance the reference model by what that cycle should do.
    task automatic step(input logic r, input logic f, input logic v, input logic [31:0] pc,
                        input logic [31:0] ins, input logic rdy);
        bit do_push, do_pop;
        @(negedge clk);
        exp_cnt = model.size();
        exp_head = exp_cnt > 0 ? model[0] : 64'h0;
        rst = r; flush = f; if_valid = v; if_pc = pc; if_instr = ins; id_ready = rdy;
        do_pop = !r && !f && rdy && model.size() > 0;
        do_push = !r && !f && v && model.size() < DEPTH;
        if (r || f) model.delete();
        else begin
            if (do_pop) exp_q.push_back(model.pop_front());
            if (do_push) model.push_back({pc, ins});
        end
    endtask
    always @(negedge clk) begin
        #4;
        if (armed) begin
            check("count", 64'(count), 64'(exp_cnt));
            check("if_ready", 64'(if_ready), 64'(exp_cnt < DEPTH));
            check("id_valid", 64'(id_valid), 64'(exp_cnt > 0));
            check("head", {id_pc, id_instr}, exp_head);
            if (id_valid && id_ready && !flush && !rst) begin
                if (exp_q.size() == 0) check("unexpected_pop", {id_pc, id_instr}, 64'hx);
                else check("pop_data", {id_pc, id_instr}, exp_q.pop_front());
            end
        end
    end
    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) step(0, 0, 1, base + 32'(4 * i), 32'h1000 + 32'(i), 0);
    endtask
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'hDEAD, 32'hBEEF, 1);
    endtask
    initial begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        armed = 1;
        step(0, 0, 1, 32'hBFC00000, 32'h24080001, 0);
        step(0, 0, 0, 32'h0, 32'h0, 0);
        drain(2);
        push_n(5, 32'h100);
        drain(5);
        push_n(2, 32'h200);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 32'h300 + 32'(4 * i), 32'h5000 + 32'(i), 1);
        drain(3);
        push_n(3, 32'h400);
        step(0, 1, 1, 32'h0BAD0BAD, 32'hFFFFFFFF, 0);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        push_n(4, 32'h500);
        step(1, 0, 1, 32'h600, 32'h6000, 1);
        step(0, 0, 0, 32'h0, 32'h0, 0);
        step(0, 0, 1, 32'h700, 32'h7000, 1);
        step(0, 0, 0, 32'h0, 32'h0, 0);
        drain(2);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(199) == 0, $urandom_range(19) == 0, $urandom_range(9) < 7,
                 $urandom, $urandom, $urandom_range(9) < 6);
        drain(DEPTH + 2);
        step(0, 0, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        #6;
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, 2..16.
REQ-002 Parameter CNTW, default 3, count width; SHALL equal log2(DEPTH)+1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 flush  input  1  discard all queued entries (branch/exception redirect).
REQ-006 if_valid  input  1  fetch side presents a valid instruction.
REQ-007 if_pc  input  32  PC of the presented instruction.
REQ-008 if_instr  input  32  presented instruction word.
REQ-009 if_ready  output  1  queue can accept a push this cycle.
REQ-010 id_valid  output  1  head entry is valid for decode.
REQ-011 id_pc  output  32  PC of head entry.
REQ-012 id_instr  output  32  instruction of head entry; this is the word fed to the decode stage and the ASCII debug decoder.
REQ-013 id_ready  input  1  decode stage accepts the head this cycle.
REQ-014 count  output  CNTW  number of valid entries, 0..DEPTH.

Function
REQ-015 Storage: DEPTH entries of {pc[31:0], instr[31:0]}, head pointer, tail pointer, occupancy counter; pointers wrap modulo DEPTH.
REQ-016 if_ready SHALL be 1 iff count < DEPTH; it SHALL NOT depend on id_ready (no push-through when full).
REQ-017 Push occurs iff if_valid & if_ready & !flush; the entry is written at tail, tail advances by 1.
REQ-018 id_valid SHALL be 1 iff count > 0; id_pc/id_instr SHALL combinationally reflect the head entry.
REQ-019 When count = 0, id_pc and id_instr SHALL be 32'h0 (id_instr reads as NOP).
REQ-020 Pop occurs iff id_valid & id_ready & !flush; head advances by 1.
REQ-021 Latency: an entry pushed in cycle N SHALL appear as id_valid in cycle N+1 at the earliest; no bypass from if_* to id_*.
REQ-022 Simultaneous push and pop (count between 1 and DEPTH-1): both SHALL occur; count unchanged.
REQ-023 Push with count = 0 and id_ready = 1: only the push occurs; count becomes 1.
REQ-024 Flush SHALL have priority over push and pop: next cycle head = tail = 0, count = 0; the same-cycle push is dropped.
REQ-025 Order SHALL be strictly FIFO; no entry is duplicated or lost except by flush/reset.
REQ-026 count SHALL never exceed DEPTH nor underflow; id_ready with count = 0 is ignored.
REQ-027 Inputs if_pc/if_instr SHALL be ignored when no push occurs.

Reset
REQ-028 With rst = 1 at a clock edge: head = tail = 0, count = 0, so if_ready = 1, id_valid = 0, id_pc = 0, id_instr = 0 from the next cycle.
REQ-029 rst SHALL take priority over flush, push and pop; reset mid-stream discards all entries.
REQ-030 Storage array contents need not be reset; outputs SHALL be forced to 0 while empty.

Verification
REQ-031 Reset, then push pc 0xBFC00000/instr 0x24080001 with id_ready = 0 -> next cycle id_valid = 1, id_pc = 0xBFC00000, id_instr = 0x24080001, count = 1.
REQ-032 Push 4 entries with id_ready = 0 -> count = 4, if_ready = 0; a 5th if_valid is not accepted; then id_ready = 1 for 4 cycles -> entries emerge in push order, count returns to 0.
REQ-033 count = 2, if_valid = 1 and id_ready = 1 every cycle for 10 cycles -> count stays 2, output sequence matches input sequence delayed by exactly 2 entries, including pointer wrap.
REQ-034 count = 3 with flush = 1 and if_valid = 1 in the same cycle -> next cycle count = 0, id_valid = 0, id_instr = 0; the pushed entry never appears.
REQ-035 count = 4, rst = 1 together with flush = 0, if_valid = 1, id_ready = 1 -> next cycle count = 0, if_ready = 1, id_valid = 0.
REQ-036 Empty queue, if_valid = 1 and id_ready = 1 -> id_valid = 0 in that cycle; next cycle id_valid = 1 with the pushed entry, count = 1.
